huffman_bit_packer: RTL and testbench

- Sits directly downstream of the Huffman translation stage.
- Consumes one translated LZ77 token per cycle: literal/length code + extra bits, distance code + extra bits.
- Concatenates the valid fields LSB-first into a continuous Deflate bit stream.
- Emits 64-bit little-endian words to the output writer, with a flush that pads the final partial word to a byte boundary.

---
 rtl/huffman_bit_packer.sv | 154 +++++++++++++++
 tb/tb_huffman_bit_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: packs translated LZ77 tokens LSB-first into 64-bit Deflate words,
// with a flush that pads the final partial word to a byte boundary.
module huffman_bit_packer #(
    parameter int OUT_W = 64,
    parameter int BUF_W = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       l_huffman_len,
    input  logic [11:0]      l_huffman_code,
    input  logic [3:0]       l_extra_len,
    input  logic [7:0]       l_extra,
    input  logic [2:0]       d_huffman_len,
    input  logic [4:0]       d_huffman_code,
    input  logic [3:0]       d_extra_len,
    input  logic [15:0]      d_extra,
    input  logic             flush,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic [3:0]       out_bytes,
    output logic             out_last,
    output logic [31:0]      bits_total,
    output logic             idle
);
    typedef enum logic {RUN, TAIL} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_s1_valid, r_s1_flush;
    logic [39:0]        r_s1_sym;
    logic [5:0]         r_s1_len;
    logic [BUF_W-1:0]   r_buf;
    logic [6:0]         r_cnt;
    logic [31:0]        r_bits;
    logic               r_out_valid, r_out_last;
    logic [OUT_W-1:0]   r_out_data;
    logic [3:0]         r_out_bytes;

    logic [3:0]         w_ll, w_le;
    logic [2:0]         w_ld;
    logic [5:0]         w_sh1, w_sh2, w_sh3, w_len;
    logic [39:0]        w_sym;
    logic               w_busy, w_take, w_fl;
    logic [BUF_W-1:0]   w_cat, w_buf_nxt;
    logic [6:0]         w_sum, w_rem, w_cnt_nxt, w_tail_cnt;
    logic               w_full, w_ov, w_ol;
    logic [OUT_W-1:0]   w_od;
    logic [3:0]         w_ob, w_tail_bytes;

    // Stage 1: clamp lengths, mask fields, concatenate into one symbol
    always_comb begin
        w_ll  = l_huffman_len > 4'd12 ? 4'd12 : l_huffman_len;
        w_le  = l_extra_len > 4'd8 ? 4'd8 : l_extra_len;
        w_ld  = d_huffman_len > 3'd5 ? 3'd5 : d_huffman_len;
        w_sh1 = 6'(w_ll);
        w_sh2 = w_sh1 + 6'(w_le);
        w_sh3 = w_sh2 + 6'(w_ld);
        w_len = w_sh3 + 6'(d_extra_len);
        w_sym = 40'(l_huffman_code & ~(12'hFFF << w_ll))
              | (40'(l_extra & ~(8'hFF << w_le)) << w_sh1)
              | (40'(d_huffman_code & ~(5'h1F << w_ld)) << w_sh2)
              | (40'(d_extra & ~(16'hFFFF << d_extra_len)) << w_sh3);
    end

    assign w_busy = (r_state == TAIL) | r_s1_flush;
    assign w_take = in_valid & ~w_busy;
    assign w_fl   = flush & ~w_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_flush <= 1'b0;
            r_s1_sym   <= '0;
            r_s1_len   <= '0;
        end else begin
            r_s1_valid <= w_take | w_fl;
            r_s1_flush <= w_fl;
            r_s1_sym   <= w_take ? w_sym : '0;
            r_s1_len   <= w_take ? w_len : '0;
        end
    end

    // Stage 2: append, emit full words, resolve flush; bits above r_cnt are always zero
    assign w_cat        = r_buf | (BUF_W'(r_s1_sym) << r_cnt);
    assign w_sum        = r_cnt + 7'(r_s1_len);
    assign w_full       = w_sum >= 7'd64;
    assign w_rem        = w_full ? w_sum - 7'd64 : w_sum;
    assign w_tail_cnt   = (r_state == TAIL) ? r_cnt : w_rem;
    assign w_tail_bytes = 4'((w_tail_cnt + 7'd7) >> 3);

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = w_full ? w_cat >> OUT_W : w_cat;
        w_cnt_nxt   = w_rem;
        w_ov        = w_full;
        w_od        = w_full ? w_cat[OUT_W-1:0] : '0;
        w_ob        = w_full ? 4'd8 : 4'd0;
        w_ol        = 1'b0;
        if (r_state == TAIL) begin
            w_ov        = 1'b1;
            w_od        = r_buf[OUT_W-1:0];
            w_ob        = w_tail_bytes;
            w_ol        = 1'b1;
            w_buf_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
        end else if (r_s1_flush) begin
            if (w_rem == 7'd0) begin
                w_ov = 1'b1;
                w_ol = 1'b1;
            end else if (w_full) begin
                w_state_nxt = TAIL;
            end else begin
                w_ov      = 1'b1;
                w_od      = w_cat[OUT_W-1:0];
                w_ob      = w_tail_bytes;
                w_ol      = 1'b1;
                w_buf_nxt = '0;
                w_cnt_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_bits      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_bytes <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bits      <= r_bits + 32'(r_s1_len);
            r_out_valid <= w_ov;
            r_out_data  <= w_ov ? w_od : '0;
            r_out_bytes <= w_ov ? w_ob : '0;
            r_out_last  <= w_ov & w_ol;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_bytes  = r_out_bytes;
    assign out_last   = r_out_last;
    assign bits_total = r_bits;
    assign idle       = ~r_s1_valid & (r_state == RUN);

    a_no_token_when_busy: assert property (@(posedge clk) disable iff (!reset) !(in_valid && w_busy));
endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer: directed table, corner sequences and randomized tokens
// checked against a bit-queue model of the packed stream.
module tb_huffman_bit_packer;
    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, flush = 1'b0;
    logic [3:0]  l_huffman_len = '0, l_extra_len = '0, d_extra_len = '0;
    logic [11:0] l_huffman_code = '0;
    logic [7:0]  l_extra = '0;
    logic [2:0]  d_huffman_len = '0;
    logic [4:0]  d_huffman_code = '0;
    logic [15:0] d_extra = '0;
    logic        out_valid, out_last, idle;
    logic [63:0] out_data;
    logic [3:0]  out_bytes;
    logic [31:0] bits_total;

    huffman_bit_packer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .l_huffman_len(l_huffman_len), .l_huffman_code(l_huffman_code),
        .l_extra_len(l_extra_len), .l_extra(l_extra),
        .d_huffman_len(d_huffman_len), .d_huffman_code(d_huffman_code),
        .d_extra_len(d_extra_len), .d_extra(d_extra),
        .flush(flush), .out_valid(out_valid), .out_data(out_data),
        .out_bytes(out_bytes), .out_last(out_last), .bits_total(bits_total), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ll; logic [11:0] lc; logic [3:0] le; logic [7:0] lx;
        logic [2:0] ld; logic [4:0] dc; logic [3:0] de; logic [15:0] dx;
    } tok_t;
    typedef struct { tok_t t; logic [63:0] d; logic [3:0] b; int unsigned bt; } vec_t;
    typedef struct { logic [63:0] d; logic [3:0] b; logic l; } word_t;

    word_t       got[$], exp_q[$];
    bit          mq[$];
    int unsigned m_bt;
    int          nvec = 0, nerr = 0;

    always @(negedge clk) if (reset && out_valid) got.push_back('{out_data, out_bytes, out_last});

    function automatic tok_t mk(logic [3:0] ll, logic [11:0] lc, logic [3:0] le, logic [7:0] lx,
                                logic [2:0] ld, logic [4:0] dc, logic [3:0] de, logic [15:0] dx);
        tok_t t;
        t.ll = ll; t.lc = lc; t.le = le; t.lx = lx; t.ld = ld; t.dc = dc; t.de = de; t.dx = dx;
        return t;
    endfunction

    function automatic vec_t mv(tok_t t, logic [63:0] d, logic [3:0] b, int unsigned bt);
        vec_t v;
        v.t = t; v.d = d; v.b = b; v.bt = bt;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic put(tok_t t, bit v, bit fl);
        @(negedge clk);
        in_valid = v; flush = fl;
        l_huffman_len = t.ll; l_huffman_code = t.lc; l_extra_len = t.le; l_extra = t.lx;
        d_huffman_len = t.ld; d_huffman_code = t.dc; d_extra_len = t.de; d_extra = t.dx;
    endtask

    task automatic nop(int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic rst();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        got.delete(); exp_q.delete(); mq.delete(); m_bt = 0;
    endtask

    function automatic void push_bits(logic [15:0] val, int n);
        for (int i = 0; i < n; i++) mq.push_back(val[i]);
        m_bt += n;
    endfunction

    function automatic void expect_word(logic [63:0] d, logic [3:0] b, logic l);
        word_t w;
        w.d = d; w.b = b; w.l = l;
        exp_q.push_back(w);
    endfunction

    // Stream model: the token's bits join a FIFO; every 64 bits leave as one word.
    function automatic void model(tok_t t, bit v, bit fl);
        logic [63:0] d;
        bit full;
        int n;
        d = '0; full = 0;
        if (v) begin
            push_bits(16'(t.lc), t.ll > 12 ? 12 : int'(t.ll));
            push_bits(16'(t.lx), t.le > 8 ? 8 : int'(t.le));
            push_bits(16'(t.dc), t.ld > 5 ? 5 : int'(t.ld));
            push_bits(t.dx, int'(t.de));
        end
        if (mq.size() >= 64) begin
            for (int i = 0; i < 64; i++) d[i] = mq.pop_front();
            full = 1;
        end
        if (fl && mq.size() == 0) begin
            expect_word(full ? d : 64'd0, full ? 4'd8 : 4'd0, 1'b1);
        end else begin
            if (full) expect_word(d, 4'd8, 1'b0);
            if (fl) begin
                n = mq.size();
                d = '0;
                for (int i = 0; i < n; i++) d[i] = mq.pop_front();
                expect_word(d, 4'((n + 7) / 8), 1'b1);
            end
        end
    endfunction

    task automatic cmp_q(string nm);
        chk({nm, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({nm, "_data"}, got[i].d, exp_q[i].d);
            chk({nm, "_bytes_last"}, {59'd0, got[i].b, got[i].l}, {59'd0, exp_q[i].b, exp_q[i].l});
        end
        got.delete(); exp_q.delete();
    endtask

    function automatic tok_t rnd_tok();
        return mk(4'($urandom), 12'($urandom), 4'($urandom), 8'($urandom),
                  3'($urandom), 5'($urandom), 4'($urandom), 16'($urandom));
    endfunction

    vec_t tbl[7];
    tok_t z, a, mx, t;

    initial begin
        z  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        a  = mk(8, 12'h0A5, 0, 0, 0, 0, 0, 0);
        mx = mk(12, 12'hFFF, 8, 8'hFF, 5, 5'h1F, 15, 16'hFFFF);
        tbl[0] = mv(mk(7, 12'h005, 1, 8'h01, 5, 5'h03, 2, 16'h0002), 64'h4385, 2, 15);
        tbl[1] = mv(mk(3, 12'hFFF, 0, 8'hFF, 7, 5'h1F, 0, 16'h0000), 64'hFF, 1, 8);
        tbl[2] = mv(mk(0, 12'hFFF, 0, 8'hFF, 0, 5'h1F, 0, 16'hFFFF), 64'h0, 0, 0);
        tbl[3] = mv(mk(15, 12'hFFF, 15, 8'hFF, 7, 5'h1F, 15, 16'hFFFF), 64'hFF_FFFF_FFFF, 5, 40);
        tbl[4] = mv(mk(12, 12'h123, 0, 8'h00, 0, 5'h00, 4, 16'h000A), 64'hA123, 2, 16);
        tbl[5] = mv(mk(0, 12'h000, 0, 8'h00, 0, 5'h00, 15, 16'h8001), 64'h0001, 2, 15);
        tbl[6] = mv(mk(1, 12'h001, 8, 8'h80, 0, 5'h00, 0, 16'h0000), 64'h101, 2, 9);

        #1;
        chk("reset_valid", 64'(out_valid), 0);
        chk("reset_idle", 64'(idle), 1);

        rst();
        repeat (8) put(a, 1, 0);
        nop(1);
        chk("t1_not_early", 64'(out_valid), 0);
        nop(1);
        chk("t1_valid", 64'(out_valid), 1);
        chk("t1_data", out_data, 64'hA5A5A5A5A5A5A5A5);
        chk("t1_bytes", 64'(out_bytes), 8);
        chk("t1_last", 64'(out_last), 0);
        chk("t1_bits_total", 64'(bits_total), 64);

        for (int i = 0; i < 7; i++) begin
            rst();
            put(tbl[i].t, 1, 1);
            nop(4);
            expect_word(tbl[i].d, tbl[i].b, 1'b1);
            cmp_q($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_bits_total", i), 64'(bits_total), 64'(tbl[i].bt));
        end

        rst();
        put(mx, 1, 0);
        put(mx, 1, 1);
        nop(5);
        expect_word(64'hFFFFFFFFFFFFFFFF, 8, 1'b0);
        expect_word(64'hFFFF, 2, 1'b1);
        cmp_q("t4");
        chk("t4_bits_total", 64'(bits_total), 80);

        rst();
        put(z, 0, 1);
        nop(4);
        expect_word(64'd0, 0, 1'b1);
        cmp_q("t5");
        chk("t5_idle", 64'(idle), 1);

        rst();
        repeat (3) put(a, 1, 0);
        nop(2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_valid", 64'(out_valid), 0);
        chk("t6_data", out_data, 0);
        chk("t6_bytes_last", {62'd0, out_bytes == 4'd0, out_last}, 64'b10);
        chk("t6_bits_total", 64'(bits_total), 0);
        chk("t6_idle", 64'(idle), 1);
        @(negedge clk);
        reset = 1'b1;
        got.delete();
        put(z, 0, 1);
        nop(4);
        expect_word(64'd0, 0, 1'b1);
        cmp_q("t6_flush");

        rst();
        for (int i = 0; i < 1500; i++) begin
            int r;
            bit v;
            r = $urandom_range(0, 99);
            t = rnd_tok();
            if (r < 70) begin
                put(t, 1, 0);
                model(t, 1, 0);
            end else if (r < 76) begin
                v = 1'($urandom);
                put(t, v, 1);
                model(t, v, 1);
                nop(3);
            end else begin
                put(t, 0, 0);
            end
        end
        put(z, 0, 1);
        model(z, 0, 1);
        nop(5);
        cmp_q("rand");
        chk("rand_bits_total", 64'(bits_total), 64'(m_bt));
        chk("rand_idle", 64'(idle), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
